// File: rtl/op_uart_pkg.sv
// Shared constants and FSM state types for the op_uart CSR UART.
package op_uart_pkg;

  localparam logic [1:0] REG_DATA = 2'b00;
  localparam logic [1:0] REG_DIV  = 2'b01;
  localparam logic [1:0] REG_THRU = 2'b10;

  localparam int OVS = 16;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/op_uart_transceiver.sv
// Baud tick generator plus 8N1 transmit and receive state machines.
// state    | meaning
// *_IDLE   | line idle, waiting for a launch (TX) or a falling edge (RX)
// *_START  | start bit: TX drives 0 for 16 ticks, RX re-checks the line at mid-bit
// *_DATA   | eight data bits, LSB first
// *_STOP   | stop bit: TX drives 1, RX samples it at mid-bit to validate the frame
module op_uart_transceiver
  import op_uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] divisor,
  input  logic        div_load,
  input  logic [15:0] div_wdata,
  input  logic        tx_start,
  input  logic [7:0]  tx_byte,
  input  logic        rx_in,
  output logic        tx_out,
  output logic        tx_done,
  output logic        rx_sync,
  output logic        rx_valid,
  output logic [7:0]  rx_byte
);

  localparam logic [3:0] TK_LAST = 4'(OVS - 1);
  localparam logic [3:0] TK_HALF = 4'(OVS / 2 - 1);

  logic [15:0] baud_cnt, load_val, div_eff;
  logic        tick;

  // A divisor write reloads straight from the bus so the new rate applies at once.
  always_comb begin
    load_val = div_load ? div_wdata : divisor;
    div_eff  = (load_val == 16'd0) ? 16'd1 : load_val;
    tick     = (baud_cnt == 16'd0);
  end

  always_ff @(posedge clk) begin
    if (rst)                   baud_cnt <= 16'd0;
    else if (div_load || tick) baud_cnt <= div_eff - 16'd1;
    else                       baud_cnt <= baud_cnt - 16'd1;
  end

  tx_state_t  tx_state, tx_next;
  logic [3:0] tx_tk;
  logic [2:0] tx_idx;
  logic [7:0] tx_sh;
  logic       tx_bit_end;

  assign tx_bit_end = tick && (tx_tk == TK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_tk    <= 4'd0;
      tx_idx   <= 3'd0;
      tx_sh    <= 8'd0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE) begin
        tx_tk  <= 4'd0;
        tx_idx <= 3'd0;
        if (tx_start) tx_sh <= tx_byte;
      end else if (tick) begin
        tx_tk <= tx_tk + 4'd1;
        if (tx_bit_end && tx_state == TX_DATA) begin
          tx_sh  <= {1'b0, tx_sh[7:1]};
          tx_idx <= tx_idx + 3'd1;
        end
      end
    end
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (tx_start) tx_next = TX_START;
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_bit_end) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_out  = 1'b1;
    tx_done = 1'b0;
    unique case (tx_state)
      TX_START: tx_out = 1'b0;
      TX_DATA:  tx_out = tx_sh[0];
      TX_STOP:  tx_done = tx_bit_end;
      default:  tx_out = 1'b1;
    endcase
  end

  logic       rx_s1, rx_s2;
  rx_state_t  rx_state, rx_next;
  logic [3:0] rx_tk;
  logic [2:0] rx_idx;
  logic [7:0] rx_sh;
  logic       rx_half, rx_bit_end;

  assign rx_half    = tick && (rx_tk == TK_HALF);
  assign rx_bit_end = tick && (rx_tk == TK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_tk    <= 4'd0;
      rx_idx   <= 3'd0;
      rx_sh    <= 8'd0;
    end else begin
      rx_s1    <= rx_in;
      rx_s2    <= rx_s1;
      rx_state <= rx_next;
      unique case (rx_state)
        RX_IDLE: begin
          rx_tk  <= 4'd0;
          rx_idx <= 3'd0;
        end
        // Realign the tick count at mid start bit so later samples land mid-bit.
        RX_START: if (tick) rx_tk <= rx_half ? 4'd0 : rx_tk + 4'd1;
        RX_DATA: if (tick) begin
          rx_tk <= rx_tk + 4'd1;
          if (rx_bit_end) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_idx <= rx_idx + 3'd1;
          end
        end
        RX_STOP: if (tick) rx_tk <= rx_tk + 4'd1;
        default: rx_tk <= 4'd0;
      endcase
    end
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (!rx_s2) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_end && rx_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_bit_end) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_valid = (rx_state == RX_STOP) && rx_bit_end && rx_s2;
    rx_sync  = rx_s2;
    rx_byte  = rx_sh;
  end

endmodule

// File: rtl/op_uart_core.sv
// CSR-mapped 8N1 UART: register decode, registered read port, irqs and thru mux.
module op_uart_core
  import op_uart_pkg::*;
#(
  parameter logic [3:0] csr_addr = 4'h0,
  parameter int         clk_freq = 50000000,
  parameter int         baud     = 115200
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        rx_irq,
  output logic        tx_irq,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam logic [15:0] DIV_DEFAULT = 16'(clk_freq / (baud * OVS));

  logic        sel, wr;
  logic [1:0]  reg_sel;
  logic [15:0] divisor;
  logic        thru;
  logic [7:0]  rx_data;
  logic        tx_out, tx_done, rx_sync, rx_valid;
  logic [7:0]  rx_byte;
  logic        unused_bits;

  assign sel         = (csr_a[13:10] == csr_addr);
  assign wr          = sel && csr_we;
  assign reg_sel     = csr_a[1:0];
  assign unused_bits = ^{csr_a[9:2], csr_di[31:16]};

  op_uart_transceiver u_xcvr (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .divisor   (divisor),
    .div_load  (wr && reg_sel == REG_DIV),
    .div_wdata (csr_di[15:0]),
    .tx_start  (wr && reg_sel == REG_DATA),
    .tx_byte   (csr_di[7:0]),
    .rx_in     (uart_rx),
    .tx_out    (tx_out),
    .tx_done   (tx_done),
    .rx_sync   (rx_sync),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte)
  );

  // Read data uses pre-update register values, so a same-cycle latch shows next read.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      divisor <= DIV_DEFAULT;
      thru    <= 1'b0;
      rx_data <= 8'd0;
      rx_irq  <= 1'b0;
      tx_irq  <= 1'b0;
      csr_do  <= 32'd0;
    end else begin
      rx_irq <= rx_valid;
      tx_irq <= tx_done;
      if (rx_valid) rx_data <= rx_byte;
      if (wr && reg_sel == REG_DIV)  divisor <= csr_di[15:0];
      if (wr && reg_sel == REG_THRU) thru    <= csr_di[0];
      if (!sel) csr_do <= 32'd0;
      else begin
        unique case (reg_sel)
          REG_DATA: csr_do <= {24'd0, rx_data};
          REG_DIV:  csr_do <= {16'd0, divisor};
          REG_THRU: csr_do <= {31'd0, thru};
          default:  csr_do <= 32'd0;
        endcase
      end
    end
  end

  assign uart_tx = thru ? rx_sync : tx_out;

endmodule

// File: tb/tb_op_uart_core.sv
// Directed bench for op_uart_core: CSR vector table plus serial-timing sequences.
module tb_op_uart_core;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [13:0] csr_a   = 14'd0;
  logic        csr_we  = 1'b0;
  logic [31:0] csr_di  = 32'd0;
  logic [31:0] csr_do;
  logic        rx_irq, tx_irq;
  logic        uart_rx, uart_tx;
  logic        loop    = 1'b0;
  logic        rx_drv  = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;

  assign uart_rx = loop ? uart_tx : rx_drv;

  always #5 sys_clk = ~sys_clk;

  op_uart_core dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_di  (csr_di),
    .csr_do  (csr_do),
    .rx_irq  (rx_irq),
    .tx_irq  (tx_irq),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx)
  );

  always @(negedge sys_clk) begin
    if (rx_irq === 1'b1) rx_cnt++;
    if (tx_irq === 1'b1) tx_cnt++;
  end

  typedef struct {
    logic [13:0] a;
    logic        we;
    logic [31:0] di;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    @(posedge sys_clk); #1;
    csr_we = 1'b0;
  endtask

  task automatic csr_read(input logic [13:0] a, output logic [31:0] d);
    csr_a = a; csr_we = 1'b0;
    @(posedge sys_clk); #1;
    d = csr_do;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  // Entered el0 edges after the launching write edge; checks each bit mid-period and irq timing.
  task automatic check_frame(input string tag, input logic [7:0] b, input int bitlen, input int el0);
    int el;
    int target;
    bit seen;
    el = el0;
    for (int k = 0; k < 10; k++) begin
      target = k * bitlen + bitlen / 2;
      repeat (target - el) @(posedge sys_clk);
      #1;
      el = target;
      check($sformatf("%s_bit%0d", tag, k), {31'd0, uart_tx}, {31'd0, frame_bit(b, k)});
    end
    seen = 1'b0;
    for (int i = 0; i < 2 * bitlen && !seen; i++) begin
      @(posedge sys_clk); #1;
      el++;
      if (tx_irq) seen = 1'b1;
    end
    check({tag, "_irq_seen"}, {31'd0, seen}, 32'd1);
    check_range({tag, "_irq_cycle"}, el, 10 * bitlen - bitlen / 16, 10 * bitlen + bitlen / 16);
  endtask

  task automatic wait_rx(input int base, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(posedge sys_clk); #1;
      if (rx_cnt > base) ok = 1'b1;
    end
  endtask

  task automatic wait_tx(input int base, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(posedge sys_clk); #1;
      if (tx_cnt > base) ok = 1'b1;
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop, input int stop_len);
    for (int k = 0; k < 9; k++) begin
      rx_drv = frame_bit(b, k);
      repeat (432) @(posedge sys_clk);
    end
    #1 rx_drv = stop;
    repeat (stop_len) @(posedge sys_clk);
    #1 rx_drv = 1'b1;
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  lb_bytes[4];
    bit          ok, low_seen;
    int          base, tbase;

    vecs[0]  = '{14'h0001, 1'b0, 32'h0,        32'd27};
    vecs[1]  = '{14'h0002, 1'b0, 32'h0,        32'd0};
    vecs[2]  = '{14'h0000, 1'b0, 32'h0,        32'd0};
    vecs[3]  = '{14'h0003, 1'b0, 32'h0,        32'd0};
    vecs[4]  = '{14'h0002, 1'b1, 32'h1,        32'd0};
    vecs[5]  = '{14'h0002, 1'b0, 32'h0,        32'd1};
    vecs[6]  = '{14'h0002, 1'b1, 32'h0,        32'd1};
    vecs[7]  = '{14'h0002, 1'b0, 32'h0,        32'd0};
    vecs[8]  = '{14'h0003, 1'b1, 32'hFFFFFFFF, 32'd0};
    vecs[9]  = '{14'h0003, 1'b0, 32'h0,        32'd0};
    vecs[10] = '{14'h0401, 1'b1, 32'h5,        32'd0};
    vecs[11] = '{14'h0401, 1'b0, 32'h0,        32'd0};
    vecs[12] = '{14'h0001, 1'b0, 32'h0,        32'd27};
    vecs[13] = '{14'h0002, 1'b1, 32'hFFFFFFFE, 32'd0};
    lb_bytes = '{8'h36, 8'h25, 8'h3A, 8'h5B};

    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_rx_irq", {31'd0, rx_irq}, 32'd0);
    check("rst_tx_irq", {31'd0, tx_irq}, 32'd0);
    check("rst_csr_do", csr_do, 32'd0);

    for (int i = 0; i < 14; i++) begin
      csr_a = vecs[i].a; csr_we = vecs[i].we; csr_di = vecs[i].di;
      @(posedge sys_clk); #1;
      check($sformatf("vec%0d", i), csr_do, vecs[i].exp);
    end
    csr_we = 1'b0;
    csr_read(14'h0002, rd);
    check("thru_bit0_only", rd, 32'd0);

    // 0x43 with the write strobe held two cycles: one frame only.
    tbase = tx_cnt;
    csr_a = 14'h0000; csr_di = 32'h43; csr_we = 1'b1;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    csr_we = 1'b0;
    check_frame("tx43", 8'h43, 432, 1);
    low_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge sys_clk); #1;
      if (uart_tx !== 1'b1) low_seen = 1'b1;
    end
    check("tx43_no_second_frame", {31'd0, low_seen}, 32'd0);
    check("tx43_irq_count", tx_cnt - tbase, 32'd1);

    loop = 1'b1;
    base = rx_cnt;
    for (int i = 0; i < 4; i++) begin
      tbase = tx_cnt;
      csr_write(14'h0000, {24'd0, lb_bytes[i]});
      wait_rx(base + i, 6000, ok);
      check($sformatf("lb%0d_rx_timeout", i), {31'd0, ok}, 32'd1);
      csr_read(14'h0000, rd);
      check($sformatf("lb%0d_data", i), rd, {24'd0, lb_bytes[i]});
      wait_tx(tbase, 6000, ok);
      check($sformatf("lb%0d_tx_timeout", i), {31'd0, ok}, 32'd1);
    end
    check("lb_rx_irq_count", rx_cnt - base, 32'd4);
    loop = 1'b0;
    repeat (500) @(posedge sys_clk);
    #1;

    base = rx_cnt;
    drive_frame(8'hC4, 1'b1, 432);
    repeat (50) @(posedge sys_clk);
    #1;
    check("rx_c4_irq_count", rx_cnt - base, 32'd1);
    csr_read(14'h0000, rd);
    check("rx_c4_data", rd, 32'h0000_00C4);

    base = rx_cnt;
    drive_frame(8'h99, 1'b0, 300);
    repeat (2000) @(posedge sys_clk);
    #1;
    check("framing_no_irq", rx_cnt - base, 32'd0);
    csr_read(14'h0000, rd);
    check("framing_data_kept", rd, 32'h0000_00C4);

    base = rx_cnt;
    rx_drv = 1'b0;
    repeat (100) @(posedge sys_clk);
    #1 rx_drv = 1'b1;
    repeat (1500) @(posedge sys_clk);
    #1;
    check("glitch_no_irq", rx_cnt - base, 32'd0);
    drive_frame(8'h81, 1'b1, 432);
    repeat (50) @(posedge sys_clk);
    #1;
    check("rx_81_irq_count", rx_cnt - base, 32'd1);
    csr_read(14'h0000, rd);
    check("rx_81_data", rd, 32'h0000_0081);

    csr_write(14'h0002, 32'h1);
    check("thru_idle_high", {31'd0, uart_tx}, 32'd1);
    rx_drv = 1'b0;
    @(posedge sys_clk); #1;
    check("thru_fall_d1", {31'd0, uart_tx}, 32'd1);
    @(posedge sys_clk); #1;
    check("thru_fall_d2", {31'd0, uart_tx}, 32'd0);
    rx_drv = 1'b1;
    @(posedge sys_clk); #1;
    check("thru_rise_d1", {31'd0, uart_tx}, 32'd0);
    @(posedge sys_clk); #1;
    check("thru_rise_d2", {31'd0, uart_tx}, 32'd1);
    csr_write(14'h0002, 32'h0);
    repeat (600) @(posedge sys_clk);
    #1;
    check("thru_off_tx_idle", {31'd0, uart_tx}, 32'd1);

    csr_write(14'h0401, 32'h9);
    csr_read(14'h0401, rd);
    check("bank1_read_zero", rd, 32'd0);
    csr_read(14'h0001, rd);
    check("bank1_write_ignored", rd, 32'd27);

    csr_write(14'h0001, 32'h4);
    csr_read(14'h0001, rd);
    check("div4_readback", rd, 32'd4);
    csr_write(14'h0000, 32'hA5);
    check_frame("txa5", 8'hA5, 64, 0);

    csr_write(14'h0000, 32'h00);
    repeat (99) @(posedge sys_clk);
    #1;
    check("midframe_low", {31'd0, uart_tx}, 32'd0);
    tbase = tx_cnt;
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    check("rst_abort_tx_high", {31'd0, uart_tx}, 32'd1);
    sys_rst = 1'b0;
    csr_read(14'h0001, rd);
    check("rst_div_default", rd, 32'd27);
    repeat (1000) @(posedge sys_clk);
    #1;
    check("rst_abort_no_irq", tx_cnt - tbase, 32'd0);
    check("rst_abort_line_idle", {31'd0, uart_tx}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/op_uart_core.md
Name: op_uart_core

Overview:
- CSR-mapped 8N1 UART with 16x oversampling and a programmable baud divisor.
- Sits on the 14-bit CSR bus, used by hosts and testbenches to exchange bytes with a serial peer.
- Provides receive and transmit completion interrupts and a pass-through ("thru") mode.

Parameters:
- csr_addr, 4'h0: CSR bank select; the block responds when csr_a[13:10] equals this value.
- clk_freq, 50000000: sys_clk frequency in Hz.
- baud, 115200: reset baud rate; reset divisor = clk_freq/(baud*16) truncated, which is 27 for the defaults.

Ports:
- sys_clk  in  1  sole clock.
- sys_rst  in  1  reset; synchronous, active-high.
- csr_a  in  14  address; [13:10] selects the bank, [1:0] selects the register.
- csr_we  in  1  write strobe.
- csr_di  in  32  write data.
- csr_do  out  32  read data, registered.
- rx_irq  out  1  one-cycle pulse when a valid byte is received.
- tx_irq  out  1  one-cycle pulse when a transmitted frame completes.
- uart_rx  in  1  serial input; asynchronous, idle high.
- uart_tx  out  1  serial output; idle high.

Behaviour:
- Selection: sel = (csr_a[13:10] == csr_addr). When sel is low, writes are ignored and csr_do is 0 on the next cycle.
- Register map, by csr_a[1:0]:
  - 00 DATA: write [7:0] launches a transmit; read returns {24'b0, last received byte}.
  - 01 DIVISOR: [15:0], read/write; reset value is the parameter-derived divisor.
  - 10 THRU: [0], read/write; reset value 0.
  - 11: reads 0; writes are ignored.
- csr_do is updated every cycle from the current csr_a, so read latency is 1 cycle.
- Reset values: csr_do=0, rx_irq=0, tx_irq=0, uart_tx=1, rx data=0, THRU=0, DIVISOR=default.
- Any reset asserted mid-frame aborts both TX and RX to idle on the next edge.
- Baud tick:
  - A 16-bit down-counter reloads with DIVISOR and pulses tick when it reaches 0, giving one tick every DIVISOR cycles.
  - The counter runs continuously.
  - Writing DIVISOR reloads the counter.
  - DIVISOR=0 is treated as 1.
  - One bit period is 16 ticks.
- TX FSM (IDLE -> START -> DATA(8, LSB first) -> STOP -> IDLE):
  - A DATA write in IDLE latches the byte and drives start bit 0 from the next cycle.
  - Each bit is held for 16 ticks.
  - At the end of the stop bit: return to IDLE and pulse tx_irq for 1 cycle.
  - A DATA write while not IDLE is ignored, so csr_we held for several cycles produces exactly one frame.
  - A frame lasts 10 bit periods (160*DIVISOR cycles nominal).
- RX FSM (IDLE -> START -> DATA -> STOP):
  - uart_rx passes through a 2-flop synchronizer.
  - IDLE: a synchronized 0 enters START.
  - START: after 8 ticks the line is resampled; if 1, the start is false and the FSM returns to IDLE, otherwise it proceeds to DATA.
  - DATA: bits are sampled every 16 ticks (mid-bit), LSB first.
  - STOP: sampled 16 ticks after the last data bit. If 1, the byte is latched into the rx data register and rx_irq pulses for 1 cycle. If 0 (framing error), the byte is discarded and no irq fires.
  - Return to IDLE occurs in either case; a new start bit is accepted immediately after.
- THRU=1: uart_tx is combinationally driven by the synchronized uart_rx; the TX FSM still runs but its output is masked. THRU=0: uart_tx comes from the TX FSM.
- Simultaneous events:
  - RX and TX are independent, so both irqs may pulse in the same cycle.
  - A read of DATA in the same cycle that a new byte is latched returns the old byte; the new byte is visible on the following read.

Decomposition:
- Package op_uart_pkg holds:
  - register offsets REG_DATA=2'b00, REG_DIV=2'b01, REG_THRU=2'b10;
  - the TX/RX FSM state enums;
  - the oversample constant OVS=16.
- One sub-module, op_uart_transceiver, holds the baud tick, TX FSM and RX FSM. The top level holds CSR decode, the registers and the thru mux.

Test Plan:
- Reset -> uart_tx=1, rx_irq=tx_irq=0; read DIVISOR returns 27, THRU returns 0, DATA returns 0.
- Write DATA=0x43 with csr_we held 2 cycles -> a single frame 0,1,1,0,0,0,0,1,0,1 with 432 cycles per bit. tx_irq pulses once, 4320±27 cycles after the write; no second frame follows.
- Loop uart_tx to uart_rx, send 0x36, 0x25, 0x3A, 0x5B back-to-back, each launched on the previous tx_irq -> four rx_irq pulses; DATA reads 0x36, 0x25, 0x3A, 0x5B in order.
- Write DIVISOR=4 and read it back -> reads 4. Send 0xA5 -> bit period 64 cycles and frame 640 cycles.
- Drive uart_rx with a frame whose stop bit is 0 -> no rx_irq and DATA unchanged. Drive a 100-cycle low glitch -> treated as a false start, no irq.
- Write THRU=1 and toggle uart_rx -> uart_tx follows with 2 cycles delay. Write with csr_a[13:10]=4'h1 -> ignored, and a read at that address gives csr_do=0.
